// File: rtl/mc_controller.sv
// Multi-cycle control FSM for a shared PC/IR/GRF/EXT/ALU/DM datapath.
// Advances one state per cycle. S_MEM is stretched to MEM_LAT cycles for data-memory access.
module mc_controller #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] NPCsel,
  output logic [1:0] EXTop,
  output logic [2:0] ALUcontrol,
  output logic       ALUSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [2:0] state,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_t     state_reg;
  logic [3:0] wait_cnt_reg;

  logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
  logic is_beq, is_lui, is_jal, is_j;
  logic is_jump, is_known, is_mem, mem_last;

  assign is_addu  = (op == OP_RTYPE) && (func == FN_ADDU);
  assign is_subu  = (op == OP_RTYPE) && (func == FN_SUBU);
  assign is_jr    = (op == OP_RTYPE) && (func == FN_JR);
  assign is_ori   = (op == OP_ORI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_lui   = (op == OP_LUI);
  assign is_jal   = (op == OP_JAL);
  assign is_j     = (op == OP_J);
  assign is_jump  = is_j || is_jal || is_jr;
  assign is_mem   = is_lw || is_sw;
  assign is_known = is_addu || is_subu || is_ori || is_lui || is_beq || is_mem || is_jump;
  assign mem_last = (wait_cnt_reg == CNT_LAST);

  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= '0;
      case (state_reg)
        S_FETCH:  state_reg <= S_DECODE;
        S_DECODE: state_reg <= (is_jump || !is_known) ? S_FETCH : S_EXEC;
        S_EXEC: begin
          if (is_beq)      state_reg <= S_FETCH;
          else if (is_mem) state_reg <= S_MEM;
          else             state_reg <= S_WB;
        end
        S_MEM: begin
          if (mem_last) begin
            state_reg <= is_lw ? S_WB : S_FETCH;
          end else begin
            state_reg    <= S_MEM;
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        S_WB:     state_reg <= S_FETCH;
        default:  state_reg <= S_FETCH;
      endcase
    end
  end

  // Datapath selects established in S_EXEC and held through S_MEM/S_WB.
  logic [2:0] exe_alu;
  logic       exe_src;
  logic [1:0] exe_ext;
  logic [1:0] wb_dst;
  logic [1:0] wb_m2r;

  always_comb begin
    exe_alu = 3'b000;
    exe_src = 1'b0;
    exe_ext = 2'b00;
    wb_dst  = 2'b00;
    wb_m2r  = 2'b00;
    if (is_subu || is_beq) exe_alu = 3'b001;
    if (is_ori)            exe_alu = 3'b010;
    if (is_ori || is_mem)  exe_src = 1'b1;
    if (is_ori)            exe_ext = 2'b01;
    if (is_lui)            exe_ext = 2'b10;
    if (is_ori || is_lui || is_lw) wb_dst = 2'b01;
    if (is_lw)             wb_m2r = 2'b01;
    if (is_lui)            wb_m2r = 2'b11;
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    NPCsel     = 2'b00;
    EXTop      = 2'b00;
    ALUcontrol = 3'b000;
    ALUSrc     = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    instr_done = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          if (is_j || is_jal) begin
            PCWrite = 1'b1;
            NPCsel  = 2'b10;
          end
          if (is_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
          if (is_jr) begin
            PCWrite = 1'b1;
            NPCsel  = 2'b11;
          end
          instr_done = is_jump || !is_known;
        end
        S_EXEC: begin
          ALUcontrol = exe_alu;
          ALUSrc     = exe_src;
          EXTop      = exe_ext;
          if (is_beq) begin
            NPCsel     = 2'b01;
            PCWrite    = zero;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          ALUcontrol = exe_alu;
          ALUSrc     = exe_src;
          EXTop      = exe_ext;
          if (is_sw && mem_last) begin
            MemWrite   = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          ALUcontrol = exe_alu;
          ALUSrc     = exe_src;
          EXTop      = exe_ext;
          RegWrite   = 1'b1;
          RegDst     = wb_dst;
          MemtoReg   = wb_m2r;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
